// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Serialises 32-bit big-endian pipeline loads/stores into byte beats on a
// single byte-wide synchronous SRAM port. The port is shared with a
// single-byte DMA/loader requester. Arbitration alternates when both sides
// are requesting, so neither side waits more than one foreign transaction.
// All SRAM strobes are registered. mem_stall is combinational so that the
// pipeline freezes in the same cycle its request appears.
module dmem_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_byte,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic [7:0]        dma_rdata,
    output logic              dma_ack,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    input  logic [7:0]        sram_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        P_BEAT = 3'd1,
        P_WAIT = 3'd2,
        P_DONE = 3'd3,
        D_BEAT = 3'd4,
        D_WAIT = 3'd5,
        D_DONE = 3'd6
    } state_t;

    localparam logic GRANT_PIPE = 1'b0;
    localparam logic GRANT_DMA  = 1'b1;

    // A byte access lives in the least significant lane of its word (big-endian).
    localparam logic [ADDR_W-1:0] BYTE_LANE_OFS = {{(ADDR_W-2){1'b0}}, 2'd3};

    // Byte idx of a big-endian word: idx 0 is the most significant byte.
    function automatic logic [7:0] word_beat(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic                grant_pipe_s;
    logic                grant_dma_s;
    logic                beat_adv_s;
    logic                last_grant_r;

    logic                we_r;
    logic                byte_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [1:0]          cnt_r;
    logic [1:0]          cnt_next_s;

    logic [23:0]         shift_r;
    logic [31:0]         mem_rdata_r;
    logic [7:0]          dma_rdata_r;
    logic                dma_ack_r;

    logic                sram_en_r;
    logic                sram_we_r;
    logic [ADDR_W-1:0]   sram_addr_r;
    logic [7:0]          sram_wdata_r;

    assign cnt_next_s = cnt_r + 2'd1;

    // Next-state logic: arbitration in IDLE, beat sequencing elsewhere.
    always_comb begin
        next_state_s = state_r;
        grant_pipe_s = 1'b0;
        grant_dma_s  = 1'b0;
        beat_adv_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (dma_req && (!mem_req || (last_grant_r == GRANT_PIPE))) begin
                    grant_dma_s  = 1'b1;
                    next_state_s = D_BEAT;
                end else if (mem_req) begin
                    grant_pipe_s = 1'b1;
                    next_state_s = P_BEAT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            P_BEAT: begin
                if (!byte_r && (cnt_r != 2'd3)) begin
                    beat_adv_s   = 1'b1;
                    next_state_s = P_BEAT;
                end else if (we_r) begin
                    next_state_s = P_DONE;
                end else begin
                    next_state_s = P_WAIT;
                end
            end
            P_WAIT: next_state_s = P_DONE;
            P_DONE: next_state_s = IDLE;
            D_BEAT: begin
                if (we_r) begin
                    next_state_s = D_DONE;
                end else begin
                    next_state_s = D_WAIT;
                end
            end
            D_WAIT:  next_state_s = D_DONE;
            D_DONE:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register and record of who was granted last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_PIPE;
        end else begin
            state_r <= next_state_s;
            if (grant_pipe_s) begin
                last_grant_r <= GRANT_PIPE;
            end else if (grant_dma_s) begin
                last_grant_r <= GRANT_DMA;
            end
        end
    end

    // Latch the granted request so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            byte_r  <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            cnt_r   <= 2'd0;
        end else if (grant_pipe_s) begin
            we_r    <= mem_we;
            byte_r  <= mem_byte;
            addr_r  <= mem_addr;
            wdata_r <= mem_wdata;
            cnt_r   <= 2'd0;
        end else if (grant_dma_s) begin
            we_r    <= dma_we;
            byte_r  <= 1'b1;
            addr_r  <= dma_addr;
            wdata_r <= {24'h00_0000, dma_wdata};
            cnt_r   <= 2'd0;
        end else if (beat_adv_s) begin
            cnt_r <= cnt_next_s;
        end
    end

    // Registered SRAM beat: the first beat launches on grant, later beats follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_en_r    <= 1'b0;
            sram_we_r    <= 1'b0;
            sram_addr_r  <= {ADDR_W{1'b0}};
            sram_wdata_r <= 8'h00;
        end else if (grant_pipe_s) begin
            sram_en_r    <= 1'b1;
            sram_we_r    <= mem_we;
            sram_addr_r  <= mem_byte ? (mem_addr + BYTE_LANE_OFS) : mem_addr;
            sram_wdata_r <= mem_byte ? mem_wdata[7:0] : mem_wdata[31:24];
        end else if (grant_dma_s) begin
            sram_en_r    <= 1'b1;
            sram_we_r    <= dma_we;
            sram_addr_r  <= dma_addr;
            sram_wdata_r <= dma_wdata;
        end else if (beat_adv_s) begin
            sram_en_r    <= 1'b1;
            sram_we_r    <= we_r;
            sram_addr_r  <= addr_r + {{(ADDR_W-2){1'b0}}, cnt_next_s};
            sram_wdata_r <= word_beat(wdata_r, cnt_next_s);
        end else begin
            sram_en_r <= 1'b0;
            sram_we_r <= 1'b0;
        end
    end

    // Capture read bytes one cycle after each read beat and produce results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r     <= 24'h00_0000;
            mem_rdata_r <= 32'h0000_0000;
            dma_rdata_r <= 8'h00;
            dma_ack_r   <= 1'b0;
        end else begin
            dma_ack_r <= (next_state_s == D_DONE);
            if ((state_r == P_BEAT) && !we_r && (cnt_r != 2'd0)) begin
                shift_r <= {shift_r[15:0], sram_rdata};
            end
            if (state_r == P_WAIT) begin
                mem_rdata_r <= byte_r ? {24'h00_0000, sram_rdata} : {shift_r, sram_rdata};
            end
            if (state_r == D_WAIT) begin
                dma_rdata_r <= sram_rdata;
            end
        end
    end

    // Held low in reset so the pipeline is released while the controller is down.
    assign mem_stall  = rst_n && mem_req && (state_r != P_DONE);
    assign mem_rdata  = mem_rdata_r;
    assign dma_rdata  = dma_rdata_r;
    assign dma_ack    = dma_ack_r;
    assign sram_en    = sram_en_r;
    assign sram_we    = sram_we_r;
    assign sram_addr  = sram_addr_r;
    assign sram_wdata = sram_wdata_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: a behavioural SRAM, a transaction-level
// reference model checked every cycle, directed scenarios with literal
// expectations, and a randomized pipeline/DMA traffic phase.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_byte = 1'b0;
    logic [9:0]  mem_addr = 10'h000;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [9:0]  dma_addr = 10'h000;
    logic [7:0]  dma_wdata = 8'h00;
    logic [7:0]  dma_rdata;
    logic        dma_ack;
    logic        sram_en, sram_we;
    logic [9:0]  sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // Behavioural byte-wide synchronous SRAM.
    logic [7:0] sram_arr [0:1023];
    bit arr_ready = 1'b0;
    always @(posedge clk) begin
        if (!arr_ready) begin
            for (int i = 0; i < 1024; i++) sram_arr[i] <= init_byte(i);
            arr_ready <= 1'b1;
        end else if (sram_en) begin
            if (sram_we) sram_arr[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_arr[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One entry per cycle following the grant cycle.
    typedef struct {
        bit         en;
        bit         we;
        logic [9:0] addr;
        logic [7:0] wdata;
        bit         pdone;
        bit         pload;
        bit         pbyte;
        logic [9:0] base;
        bit         ack;
        bit         dread;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  ref_mem [0:1023];
    bit          m_last_dma;
    logic [31:0] m_rdata;
    int          grant_cnt;

    function automatic exp_t blank();
        exp_t e;
        e.en = 1'b0; e.we = 1'b0; e.addr = 10'h000; e.wdata = 8'h00;
        e.pdone = 1'b0; e.pload = 1'b0; e.pbyte = 1'b0; e.base = 10'h000;
        e.ack = 1'b0; e.dread = 1'b0;
        return e;
    endfunction

    task automatic model_grant();
        exp_t e;
        int   n;
        if (dma_req && (!mem_req || !m_last_dma)) begin
            m_last_dma = 1'b1;
            grant_cnt++;
            e = blank(); e.en = 1'b1; e.we = dma_we; e.addr = dma_addr; e.wdata = dma_wdata;
            q.push_back(e);
            if (!dma_we) q.push_back(blank());
            e = blank(); e.ack = 1'b1; e.dread = !dma_we; e.base = dma_addr;
            q.push_back(e);
        end else if (mem_req) begin
            m_last_dma = 1'b0;
            grant_cnt++;
            n = mem_byte ? 1 : 4;
            for (int k = 0; k < n; k++) begin
                e = blank(); e.en = 1'b1; e.we = mem_we;
                e.addr  = mem_byte ? mem_addr + 10'd3 : mem_addr + 10'(k);
                e.wdata = mem_byte ? mem_wdata[7:0] : 8'(mem_wdata >> (24 - 8 * k));
                q.push_back(e);
            end
            if (!mem_we) q.push_back(blank());
            e = blank(); e.pdone = 1'b1; e.pload = !mem_we; e.pbyte = mem_byte; e.base = mem_addr;
            q.push_back(e);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    task automatic monitor();
        exp_t cur;
        bit   idle;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_last_dma = 1'b0;
                m_rdata    = 32'h0;
                chk("rst_sram_en", sram_en, 0);
                chk("rst_sram_we", sram_we, 0);
                chk("rst_sram_addr", sram_addr, 0);
                chk("rst_sram_wdata", sram_wdata, 0);
                chk("rst_mem_stall", mem_stall, 0);
                chk("rst_mem_rdata", mem_rdata, 0);
                chk("rst_dma_ack", dma_ack, 0);
                chk("rst_dma_rdata", dma_rdata, 0);
            end else begin
                idle = (q.size() == 0);
                cur  = idle ? blank() : q.pop_front();
                if (cur.en && cur.we) ref_mem[cur.addr] = cur.wdata;
                if (cur.pdone && cur.pload) begin
                    m_rdata = cur.pbyte ? {24'h0, ref_mem[cur.base + 10'd3]}
                                        : {ref_mem[cur.base], ref_mem[cur.base + 10'd1],
                                           ref_mem[cur.base + 10'd2], ref_mem[cur.base + 10'd3]};
                end
                chk("sram_en", sram_en, cur.en);
                if (cur.en) begin
                    chk("sram_we", sram_we, cur.we);
                    chk("sram_addr", sram_addr, cur.addr);
                    if (cur.we) chk("sram_wdata", sram_wdata, cur.wdata);
                end
                chk("mem_stall", mem_stall, mem_req && !cur.pdone);
                chk("mem_rdata", mem_rdata, m_rdata);
                chk("dma_ack", dma_ack, cur.ack);
                if (cur.ack && cur.dread) chk("dma_rdata", dma_rdata, ref_mem[cur.base]);
                if (idle) model_grant();
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic wait_pipe(output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            else begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("pipe_timeout", 1, 0);
    endtask

    task automatic pipe_op(input bit we, input bit byt, input logic [9:0] a,
                           input logic [31:0] wd, output int stalls, output logic [31:0] rd);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = we; mem_byte = byt; mem_addr = a; mem_wdata = wd;
        wait_pipe(stalls);
        rd = mem_rdata;
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic wait_ack(output logic [7:0] rd);
        bit ok;
        ok = 1'b0;
        rd = 8'h00;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dma_ack) begin
                ok = 1'b1;
                rd = dma_rdata;
                break;
            end
        end
        if (!ok) chk("dma_timeout", 1, 0);
    endtask

    function automatic logic [9:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 10'($urandom_range(0, 31));
        else return 10'($urandom_range(1016, 1023));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          st;
        logic [31:0] rd;
        logic [7:0]  drd;
        bit          order[$];
        int          acks;
        bit          prev_en;
        bit          p_done, d_ack;
        int          mism;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
        m_last_dma = 1'b0;
        m_rdata    = 32'h0;
        grant_cnt  = 0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Word store then word load at 0x010.
        pipe_op(1'b1, 1'b0, 10'h010, 32'hDEADBEEF, st, rd);
        chk("wstore_stall", st, 5);
        chk("wstore_bytes", {sram_arr[16], sram_arr[17], sram_arr[18], sram_arr[19]}, 32'hDEADBEEF);
        pipe_op(1'b0, 1'b0, 10'h010, 32'h0, st, rd);
        chk("wload_stall", st, 6);
        chk("wload_rdata", rd, 32'hDEADBEEF);

        // Byte store then byte load at 0x020.
        pipe_op(1'b1, 1'b1, 10'h020, 32'hFFFF_FFA5, st, rd);
        chk("bstore_stall", st, 2);
        chk("bstore_byte", sram_arr[35], 8'hA5);
        chk("bstore_others", {sram_arr[32], sram_arr[33], sram_arr[34]},
            {init_byte(32'h20), init_byte(32'h21), init_byte(32'h22)});
        pipe_op(1'b0, 1'b1, 10'h020, 32'h0, st, rd);
        chk("bload_stall", st, 3);
        chk("bload_rdata", rd, 32'h0000_00A5);
        // A store leaves the last load result in place.
        pipe_op(1'b1, 1'b0, 10'h060, 32'h0BAD_F00D, st, rd);
        chk("store_keeps_rdata", mem_rdata, 32'h0000_00A5);

        // Word store across the top of the address space.
        pipe_op(1'b1, 1'b0, 10'h3FE, 32'h11223344, st, rd);
        chk("wrap_stall", st, 5);
        chk("wrap_bytes", {sram_arr[1022], sram_arr[1023], sram_arr[0], sram_arr[1]}, 32'h11223344);

        // DMA write, then DMA read with a pipeline request arriving meanwhile.
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h100; dma_wdata = 8'h5A;
        wait_ack(drd);
        @(posedge clk); #1;
        dma_req = 1'b0;
        @(negedge clk);
        chk("dma_ack_pulse_w", dma_ack, 0);
        chk("dma_write_byte", sram_arr[256], 8'h5A);
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h100;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; mem_byte = 1'b1; mem_addr = 10'h020;
        @(negedge clk);
        chk("stall_during_dma", mem_stall, 1);
        wait_ack(drd);
        chk("dma_read_data", drd, 8'h5A);
        @(posedge clk); #1;
        dma_req = 1'b0;
        @(negedge clk);
        chk("dma_ack_pulse_r", dma_ack, 0);
        wait_pipe(st);
        chk("pipe_after_dma", mem_rdata, 32'h0000_00A5);
        @(posedge clk); #1;
        mem_req = 1'b0;

        // Both requesters held from reset: grants alternate, DMA first.
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mem_byte = 1'b0; mem_addr = 10'h040; mem_wdata = 32'h01020304;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h200; dma_wdata = 8'h77;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        acks = 0;
        prev_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dma_ack) acks++;
            if (sram_en && !prev_en) order.push_back(sram_addr == 10'h200);
            prev_en = sram_en;
            if (order.size() == 4) break;
        end
        if (order.size() != 4) chk("alt_timeout", 1, 0);
        else for (int i = 0; i < 4; i++) chk($sformatf("grant_order_%0d_is_dma", i), order[i], (i % 2 == 0) ? 1 : 0);
        chk("alt_ack_count", acks, 2);
        @(posedge clk); #1;
        mem_req = 1'b0; dma_req = 1'b0;
        repeat (8) @(posedge clk);

        // Reset during beat 2 of a word store.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_byte = 1'b0; mem_addr = 10'h080; mem_wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        chk("beat2_en", sram_en, 1);
        chk("beat2_addr", sram_addr, 10'h082);
        rst_n = 1'b0;
        #1;
        chk("rst_async_en", sram_en, 0);
        chk("rst_async_stall", mem_stall, 0);
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("partial_store", {sram_arr[128], sram_arr[129], sram_arr[130], sram_arr[131]},
            {8'hCA, 8'hFE, init_byte(32'h82), init_byte(32'h83)});
        pipe_op(1'b0, 1'b1, 10'h080, 32'h0, st, rd);
        chk("post_rst_bload_stall", st, 3);
        chk("post_rst_bload", rd, {24'h0, init_byte(32'h83)});
        pipe_op(1'b0, 1'b0, 10'h080, 32'h0, st, rd);
        chk("post_rst_wload_stall", st, 6);
        chk("post_rst_wload", rd, {8'hCA, 8'hFE, init_byte(32'h82), init_byte(32'h83)});

        // Randomized traffic from both requesters.
        grant_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            p_done = mem_req && !mem_stall;
            d_ack  = dma_ack;
            @(posedge clk); #1;
            if (!mem_req || p_done) begin
                mem_req   = ($urandom_range(0, 9) < 6);
                mem_we    = 1'($urandom_range(0, 1));
                mem_byte  = 1'($urandom_range(0, 1));
                mem_addr  = rand_addr();
                mem_wdata = $urandom;
            end
            if (!dma_req || d_ack) begin
                dma_req   = ($urandom_range(0, 9) < 3);
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = rand_addr();
                dma_wdata = 8'($urandom);
            end
        end
        mem_req = 1'b0;
        dma_req = 1'b0;
        repeat (12) @(posedge clk);
        chk("random_grants_seen", (grant_cnt > 100) ? 1 : 0, 1);

        mism = 0;
        for (int i = 0; i < 1024; i++) if (sram_arr[i] !== ref_mem[i]) mism++;
        chk("mem_image_mismatches", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
